// File: rtl/branch_update_unit_pkg.sv
// Shared widths and helpers for the branch update path.
//   REG_WIDTH          : architectural register / PC width.
//   update_bus_width() : packed width of one update entry {pc, taken, target}.
package branch_update_unit_pkg;

  localparam int unsigned REG_WIDTH = 32;

  function automatic int unsigned update_bus_width(input int unsigned addr_width);
    return 2 * addr_width + 1;
  endfunction

endpackage

// File: rtl/bpu_update_fifo.sv
// First-word-fall-through circular FIFO feeding the predictor update port.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push, data : write request and entry (ignored while full)
//   pop        : read request (ignored while empty)
//   full/empty : occupancy flags, derived only from registered state
//   head       : oldest entry, valid whenever !empty
module bpu_update_fifo #(
  parameter int unsigned DEPTH_EXP2 = 2,
  parameter int unsigned WIDTH      = 65
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned DEPTH = 1 << DEPTH_EXP2;
  localparam logic [DEPTH_EXP2:0] DEPTH_CNT = (DEPTH_EXP2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_EXP2-1:0] wr_ptr;
  logic [DEPTH_EXP2-1:0] rd_ptr;
  logic [DEPTH_EXP2:0]   count;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // Storage cleared too so the update data outputs read zero after reset.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/branch_update_unit.sv
// Producer side of the predictor update interface.
// Accepts resolved branches from EX, flags mispredictions (registered
// one-cycle pulse plus corrected fetch PC), queues every accepted branch in
// a FWFT FIFO and drains it one per cycle onto the predictor update port.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   ex_valid_i / ex_ready_o        : EX handshake (ready = FIFO not full)
//   ex_pc_i, ex_taken_i, ex_target_i            : resolved branch
//   ex_pred_taken_i, ex_pred_target_i           : prediction carried down
//   update_ready_i                 : predictor accepts an update
//   branch_valid_o/taken_o/pc_o/target_address_o: update port (FIFO head)
//   mispredict_o, redirect_pc_o    : registered redirect to frontend
//   perf_branch_count_o, perf_mispredict_count_o: performance counters
module branch_update_unit
  import branch_update_unit_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH_EXP2 = 2,
  parameter int unsigned ADDR_WIDTH      = REG_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid_i,
  output logic                  ex_ready_o,
  input  logic [ADDR_WIDTH-1:0] ex_pc_i,
  input  logic                  ex_taken_i,
  input  logic [ADDR_WIDTH-1:0] ex_target_i,
  input  logic                  ex_pred_taken_i,
  input  logic [ADDR_WIDTH-1:0] ex_pred_target_i,
  input  logic                  update_ready_i,
  output logic                  branch_valid_o,
  output logic                  branch_taken_o,
  output logic [ADDR_WIDTH-1:0] branch_pc_o,
  output logic [ADDR_WIDTH-1:0] branch_target_address_o,
  output logic                  mispredict_o,
  output logic [ADDR_WIDTH-1:0] redirect_pc_o,
  output logic [31:0]           perf_branch_count_o,
  output logic [31:0]           perf_mispredict_count_o
);

  localparam int unsigned ENTRY_W = update_bus_width(ADDR_WIDTH);

  logic               accept;
  logic               mispredict;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_head;
  logic [ENTRY_W-1:0] fifo_data;

  assign ex_ready_o = !fifo_full;
  assign accept     = ex_valid_i && ex_ready_o;
  assign fifo_data  = {ex_pc_i, ex_taken_i, ex_target_i};

  // A wrong target only matters when the branch was actually taken.
  always_comb begin
    mispredict = 1'b0;
    if (ex_pred_taken_i != ex_taken_i) begin
      mispredict = 1'b1;
    end else if (ex_taken_i && (ex_pred_target_i != ex_target_i)) begin
      mispredict = 1'b1;
    end
  end

  bpu_update_fifo #(
    .DEPTH_EXP2 (FIFO_DEPTH_EXP2),
    .WIDTH      (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .data  (fifo_data),
    .pop   (update_ready_i),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign branch_valid_o          = !fifo_empty;
  assign branch_pc_o             = fifo_head[ENTRY_W-1 -: ADDR_WIDTH];
  assign branch_taken_o          = fifo_head[ADDR_WIDTH];
  assign branch_target_address_o = fifo_head[ADDR_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict_o            <= 1'b0;
      redirect_pc_o           <= '0;
      perf_branch_count_o     <= '0;
      perf_mispredict_count_o <= '0;
    end else begin
      mispredict_o <= accept && mispredict;
      if (accept) begin
        perf_branch_count_o <= perf_branch_count_o + 32'd1;
        if (mispredict) begin
          perf_mispredict_count_o <= perf_mispredict_count_o + 32'd1;
          redirect_pc_o <= ex_taken_i ? ex_target_i
                                      : ex_pc_i + ADDR_WIDTH'(4);
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_update_unit.sv
module tb_branch_update_unit;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } upd_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [31:0] ex_pc_i;
  logic        ex_taken_i;
  logic [31:0] ex_target_i;
  logic        ex_pred_taken_i;
  logic [31:0] ex_pred_target_i;
  logic        update_ready_i;
  logic        branch_valid_o;
  logic        branch_taken_o;
  logic [31:0] branch_pc_o;
  logic [31:0] branch_target_address_o;
  logic        mispredict_o;
  logic [31:0] redirect_pc_o;
  logic [31:0] perf_branch_count_o;
  logic [31:0] perf_mispredict_count_o;

  int vectors     = 0;
  int miscompares = 0;

  upd_t        sb[$];
  logic        exp_mis;
  logic [31:0] exp_redir;
  logic [31:0] exp_bcnt;
  logic [31:0] exp_mcnt;
  logic        a;

  always #5 clk = ~clk;

  branch_update_unit #(
    .FIFO_DEPTH_EXP2 (2),
    .ADDR_WIDTH      (32)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .ex_valid_i              (ex_valid_i),
    .ex_ready_o              (ex_ready_o),
    .ex_pc_i                 (ex_pc_i),
    .ex_taken_i              (ex_taken_i),
    .ex_target_i             (ex_target_i),
    .ex_pred_taken_i         (ex_pred_taken_i),
    .ex_pred_target_i        (ex_pred_target_i),
    .update_ready_i          (update_ready_i),
    .branch_valid_o          (branch_valid_o),
    .branch_taken_o          (branch_taken_o),
    .branch_pc_o             (branch_pc_o),
    .branch_target_address_o (branch_target_address_o),
    .mispredict_o            (mispredict_o),
    .redirect_pc_o           (redirect_pc_o),
    .perf_branch_count_o     (perf_branch_count_o),
    .perf_mispredict_count_o (perf_mispredict_count_o)
  );

  // Drive one cycle of stimulus, advance the clock, update the reference model.
  task automatic tick(input logic r, input logic v, input logic [31:0] pc,
                      input logic tk, input logic [31:0] tg, input logic pt,
                      input logic [31:0] ptg, input logic ur, output logic acc);
    logic pop;
    logic mis;
    upd_t e;
    rst = r; ex_valid_i = v; ex_pc_i = pc; ex_taken_i = tk; ex_target_i = tg;
    ex_pred_taken_i = pt; ex_pred_target_i = ptg; update_ready_i = ur;
    acc = !r && v && (sb.size() < DEPTH);
    pop = !r && (sb.size() != 0) && ur;
    mis = (pt != tk) || (tk && (ptg != tg));
    @(posedge clk);
    if (r) begin
      sb.delete();
      exp_mis = 1'b0; exp_redir = '0; exp_bcnt = '0; exp_mcnt = '0;
    end else begin
      if (pop) void'(sb.pop_front());
      if (acc) begin
        e.pc = pc; e.taken = tk; e.target = tg;
        sb.push_back(e);
        exp_bcnt = exp_bcnt + 32'd1;
        if (mis) begin
          exp_mcnt  = exp_mcnt + 32'd1;
          exp_redir = tk ? tg : pc + 32'd4;
        end
      end
      exp_mis = acc && mis;
    end
    #1;
  endtask

  task automatic idle(input logic ur);
    tick(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, ur, a);
  endtask

  task automatic test_reset;
    tick(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, a);
    tick(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, a);
    for (int i = 0; i < 5; i++) begin
      idle(1'b0);
      vectors++;
      if ({branch_valid_o, mispredict_o, ex_ready_o} !== 3'b001) begin
        miscompares++;
        $display("FAIL reset_flags cyc%0d: valid/mis/ready=%b want 001", i,
                 {branch_valid_o, mispredict_o, ex_ready_o});
      end
      vectors++;
      if ({perf_branch_count_o, perf_mispredict_count_o, branch_pc_o,
           branch_target_address_o, branch_taken_o, redirect_pc_o} !== '0) begin
        miscompares++;
        $display("FAIL reset_values cyc%0d: bcnt=%h mcnt=%h pc=%h tgt=%h redir=%h want 0", i,
                 perf_branch_count_o, perf_mispredict_count_o, branch_pc_o,
                 branch_target_address_o, redirect_pc_o);
      end
    end
  endtask

  task automatic test_correct;
    tick(1'b0, 1'b1, 32'h1c000100, 1'b1, 32'h1c000200, 1'b1, 32'h1c000200, 1'b1, a);
    vectors++;
    if (branch_valid_o !== 1'b1 || sb.size() == 0) begin
      miscompares++;
      $display("FAIL correct_valid: got %b want 1", branch_valid_o);
    end else begin
      vectors++;
      if ({branch_pc_o, branch_taken_o, branch_target_address_o} !== sb[0]) begin
        miscompares++;
        $display("FAIL correct_head: got %h/%b/%h want %h/%b/%h", branch_pc_o,
                 branch_taken_o, branch_target_address_o, sb[0].pc, sb[0].taken, sb[0].target);
      end
    end
    vectors++;
    if (mispredict_o !== 1'b0 || perf_branch_count_o !== 32'd1) begin
      miscompares++;
      $display("FAIL correct_mis_cnt: mis=%b bcnt=%0d want 0/1", mispredict_o, perf_branch_count_o);
    end
    idle(1'b1);
    vectors++;
    if (branch_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL correct_drain: valid=%b want 0", branch_valid_o);
    end
  endtask

  task automatic test_dir_mispredict;
    tick(1'b0, 1'b1, 32'h1c000300, 1'b0, 32'h1c000500, 1'b1, 32'h1c000500, 1'b1, a);
    vectors++;
    if (mispredict_o !== 1'b1 || redirect_pc_o !== 32'h1c000304) begin
      miscompares++;
      $display("FAIL dir_mis: mis=%b redir=%h want 1/1c000304", mispredict_o, redirect_pc_o);
    end
    vectors++;
    if (perf_mispredict_count_o !== exp_mcnt || perf_branch_count_o !== exp_bcnt) begin
      miscompares++;
      $display("FAIL dir_cnt: mcnt=%0d bcnt=%0d want %0d/%0d", perf_mispredict_count_o,
               perf_branch_count_o, exp_mcnt, exp_bcnt);
    end
    vectors++;
    if (sb.size() == 0 || {branch_pc_o, branch_taken_o, branch_target_address_o} !== sb[0]) begin
      miscompares++;
      $display("FAIL dir_head: got %h/%b/%h", branch_pc_o, branch_taken_o, branch_target_address_o);
    end
    idle(1'b1);
    vectors++;
    if (mispredict_o !== 1'b0 || redirect_pc_o !== 32'h1c000304) begin
      miscompares++;
      $display("FAIL dir_pulse_end: mis=%b redir=%h want 0/1c000304", mispredict_o, redirect_pc_o);
    end
  endtask

  task automatic test_target_mispredict;
    tick(1'b0, 1'b1, 32'h1c000700, 1'b1, 32'h1c000800, 1'b1, 32'h1c000400, 1'b1, a);
    vectors++;
    if (mispredict_o !== 1'b1 || redirect_pc_o !== 32'h1c000800) begin
      miscompares++;
      $display("FAIL tgt_mis: mis=%b redir=%h want 1/1c000800", mispredict_o, redirect_pc_o);
    end
    tick(1'b0, 1'b1, 32'h1c000900, 1'b0, 32'h1c000a00, 1'b0, 32'h1c000b00, 1'b1, a);
    vectors++;
    if (mispredict_o !== 1'b0 || redirect_pc_o !== 32'h1c000800
        || perf_mispredict_count_o !== exp_mcnt) begin
      miscompares++;
      $display("FAIL nt_tgt_mismatch: mis=%b redir=%h mcnt=%0d want 0/1c000800/%0d",
               mispredict_o, redirect_pc_o, perf_mispredict_count_o, exp_mcnt);
    end
    // Fall-through PC wraps at the top of the address space.
    tick(1'b0, 1'b1, 32'hfffffffc, 1'b0, 32'h00001000, 1'b1, 32'h00001000, 1'b1, a);
    vectors++;
    if (mispredict_o !== 1'b1 || redirect_pc_o !== 32'h00000000) begin
      miscompares++;
      $display("FAIL redir_wrap: mis=%b redir=%h want 1/00000000", mispredict_o, redirect_pc_o);
    end
    for (int i = 0; i < 8 && sb.size() != 0; i++) idle(1'b1);
    vectors++;
    if (branch_valid_o !== 1'b0 || perf_branch_count_o !== exp_bcnt) begin
      miscompares++;
      $display("FAIL tgt_drain: valid=%b bcnt=%0d want 0/%0d", branch_valid_o,
               perf_branch_count_o, exp_bcnt);
    end
  endtask

  task automatic test_backpressure;
    int k = 0;
    int n;
    logic [31:0] pc;
    logic [31:0] tg;
    logic        tk;
    for (int i = 0; i < 5; i++) begin
      pc = 32'h20000000 + 32'(k * 16); tg = 32'h30000000 + 32'(k * 32); tk = k[0];
      tick(1'b0, 1'b1, pc, tk, tg, tk, tg, 1'b0, a);
      if (a) k++;
      vectors++;
      if (sb.size() == 0 || {branch_pc_o, branch_taken_o, branch_target_address_o} !== sb[0]
          || branch_pc_o !== 32'h20000000) begin
        miscompares++;
        $display("FAIL bp_head_hold cyc%0d: pc=%h want 20000000", i, branch_pc_o);
      end
    end
    vectors++;
    if (ex_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_full: ready=%b want 0", ex_ready_o);
    end
    n = 0;
    while ((k < 5 || sb.size() != 0) && n < 12) begin
      vectors++;
      if (ex_ready_o !== (sb.size() < DEPTH)) begin
        miscompares++;
        $display("FAIL bp_ready cyc%0d: got %b want %b", n, ex_ready_o, sb.size() < DEPTH);
      end
      pc = 32'h20000000 + 32'(k * 16); tg = 32'h30000000 + 32'(k * 32); tk = k[0];
      tick(1'b0, k < 5, pc, tk, tg, tk, tg, 1'b1, a);
      if (a) k++;
      vectors++;
      if (branch_valid_o !== (sb.size() != 0)) begin
        miscompares++;
        $display("FAIL bp_valid cyc%0d: got %b want %b", n, branch_valid_o, sb.size() != 0);
      end else if (sb.size() != 0) begin
        vectors++;
        if ({branch_pc_o, branch_taken_o, branch_target_address_o} !== sb[0]) begin
          miscompares++;
          $display("FAIL bp_order cyc%0d: got %h/%b/%h want %h/%b/%h", n, branch_pc_o,
                   branch_taken_o, branch_target_address_o, sb[0].pc, sb[0].taken, sb[0].target);
        end
      end
      n++;
    end
    vectors++;
    if (n >= 12 || perf_branch_count_o !== exp_bcnt) begin
      miscompares++;
      $display("FAIL bp_complete: cycles=%0d bcnt=%0d want <12/%0d", n,
               perf_branch_count_o, exp_bcnt);
    end
  endtask

  task automatic test_push_pop;
    tick(1'b0, 1'b1, 32'h40000000, 1'b1, 32'h40000100, 1'b1, 32'h40000100, 1'b0, a);
    tick(1'b0, 1'b1, 32'h40000010, 1'b0, 32'h40000110, 1'b0, 32'h40000110, 1'b0, a);
    tick(1'b0, 1'b1, 32'h40000020, 1'b1, 32'h40000120, 1'b1, 32'h40000120, 1'b1, a);
    vectors++;
    if (branch_valid_o !== 1'b1 || branch_pc_o !== 32'h40000010 || ex_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL pp_head: valid=%b pc=%h ready=%b want 1/40000010/1", branch_valid_o,
               branch_pc_o, ex_ready_o);
    end
    tick(1'b0, 1'b1, 32'h40000030, 1'b0, 32'h40000130, 1'b0, 32'h40000130, 1'b0, a);
    vectors++;
    if (ex_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL pp_occ3: ready=%b want 1", ex_ready_o);
    end
    tick(1'b0, 1'b1, 32'h40000040, 1'b1, 32'h40000140, 1'b1, 32'h40000140, 1'b0, a);
    vectors++;
    if (ex_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL pp_occ4: ready=%b want 0", ex_ready_o);
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 8 && sb.size() != 0; i++) idle(1'b1);
    tick(1'b0, 1'b1, 32'h50000000, 1'b1, 32'h50000800, 1'b0, 32'h50000800, 1'b0, a);
    vectors++;
    if (mispredict_o !== 1'b1 || redirect_pc_o !== 32'h50000800 || branch_valid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rm_pre: mis=%b redir=%h valid=%b want 1/50000800/1", mispredict_o,
               redirect_pc_o, branch_valid_o);
    end
    tick(1'b1, 1'b1, 32'h50000100, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, a);
    vectors++;
    if ({branch_valid_o, mispredict_o, ex_ready_o} !== 3'b001
        || perf_branch_count_o !== 32'd0 || perf_mispredict_count_o !== 32'd0) begin
      miscompares++;
      $display("FAIL rm_post: valid/mis/ready=%b bcnt=%0d mcnt=%0d want 001/0/0",
               {branch_valid_o, mispredict_o, ex_ready_o}, perf_branch_count_o,
               perf_mispredict_count_o);
    end
    idle(1'b1);
    vectors++;
    if (branch_valid_o !== 1'b0 || mispredict_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rm_after: valid=%b mis=%b want 0/0", branch_valid_o, mispredict_o);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ex_valid_i = 1'b0; ex_pc_i = '0; ex_taken_i = 1'b0; ex_target_i = '0;
    ex_pred_taken_i = 1'b0; ex_pred_target_i = '0; update_ready_i = 1'b0;
    exp_mis = 1'b0; exp_redir = '0; exp_bcnt = '0; exp_mcnt = '0;
    test_reset;
    test_correct;
    test_dir_mispredict;
    test_target_mispredict;
    test_backpressure;
    test_push_pop;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
